// File: rtl/dmi_initiator_if.sv
// DMI initiator bus bundle: transport-side request/response plus the DM register access port.
// The master modport is the initiator's view; slave is the transport/DM environment's view.
interface dmi_initiator_if #(
  parameter int unsigned ABITS = 7
) ();
  logic             iReqValid;
  logic [1:0]       iReqOp;
  logic [ABITS-1:0] iReqAddr;
  logic [31:0]      iReqData;
  logic             iDmiReset;
  logic             iDmiHardReset;
  logic             oReqReady;
  logic             oRespValid;
  logic [1:0]       oRespOp;
  logic [31:0]      oRespData;
  logic [1:0]       oDmiStat;
  logic [ABITS-1:0] oDmAddr;
  logic [31:0]      oDmWdata;
  logic             oDmWrite;
  logic             oDmAccessValid;
  logic [31:0]      iDmRdata;
  logic             iDmAck;
  logic             iDmError;

  modport master (
    input  iReqValid, iReqOp, iReqAddr, iReqData, iDmiReset, iDmiHardReset,
    input  iDmRdata, iDmAck, iDmError,
    output oReqReady, oRespValid, oRespOp, oRespData, oDmiStat,
    output oDmAddr, oDmWdata, oDmWrite, oDmAccessValid
  );

  modport slave (
    output iReqValid, iReqOp, iReqAddr, iReqData, iDmiReset, iDmiHardReset,
    output iDmRdata, iDmAck, iDmError,
    input  oReqReady, oRespValid, oRespOp, oRespData, oDmiStat,
    input  oDmAddr, oDmWdata, oDmWrite, oDmAccessValid
  );
endinterface

// File: rtl/dmi_initiator.sv
// DMI bus master: accepts one transport-side DMI op, performs a single DM register access and
// returns a one-cycle status/data response, tracking the sticky dmistat.
module dmi_initiator #(
  parameter int unsigned ABITS   = 7,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             iClk,
  input logic             iRst,
  dmi_initiator_if.master bus
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  localparam logic [1:0] StatOk     = 2'd0;
  localparam logic [1:0] StatFailed = 2'd2;
  localparam logic [1:0] StatBusy   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       stat_q, stat_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       resp_op_q, resp_op_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             in_access, in_resp;

  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_op_d   = resp_op_q;
    resp_data_d = resp_data_q;
    case (state_q)
      StIdle: begin
        if (bus.iReqValid) begin
          op_d    = bus.iReqOp;
          addr_d  = bus.iReqAddr;
          wdata_d = bus.iReqData;
          // A pending sticky error or a nop short-circuits straight to the response.
          if (stat_q != StatOk || (bus.iReqOp != OpRead && bus.iReqOp != OpWrite)) begin
            state_d     = StResp;
            resp_op_d   = stat_q;
            resp_data_d = '0;
          end else begin
            state_d = StAccess;
            cnt_d   = CntW'(1);
          end
        end
      end
      StAccess: begin
        if (bus.iDmAck) begin
          state_d     = StResp;
          resp_op_d   = bus.iDmError ? StatFailed : StatOk;
          resp_data_d = (op_q == OpRead) ? bus.iDmRdata : '0;
          if (bus.iDmError && stat_q == StatOk) stat_d = StatFailed;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          state_d     = StResp;
          resp_op_d   = StatFailed;
          resp_data_d = '0;
          if (stat_q == StatOk) stat_d = StatFailed;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        // A failure recorded this same cycle takes precedence over the busy violation.
        if (bus.iReqValid && stat_d == StatOk) stat_d = StatBusy;
      end
      StResp: begin
        state_d = StIdle;
        cnt_d   = '0;
        if (bus.iReqValid && stat_q == StatOk) stat_d = StatBusy;
      end
      default: state_d = StIdle;
    endcase
    if (bus.iDmiReset) stat_d = StatOk;
    if (bus.iDmiHardReset) begin
      state_d = StIdle;
      stat_d  = StatOk;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= StIdle;
      stat_q      <= StatOk;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_op_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_op_q   <= resp_op_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);

  assign bus.oReqReady      = (state_q == StIdle);
  assign bus.oRespValid     = in_resp;
  assign bus.oRespOp        = in_resp ? resp_op_q : '0;
  assign bus.oRespData      = in_resp ? resp_data_q : '0;
  assign bus.oDmiStat       = stat_q;
  assign bus.oDmAccessValid = in_access;
  assign bus.oDmWrite       = in_access && (op_q == OpWrite);
  assign bus.oDmAddr        = in_access ? addr_q : '0;
  assign bus.oDmWdata       = in_access ? wdata_q : '0;
endmodule

// File: doc/dmi_initiator.md
Name: dmi_initiator

Overview:
- Debug-transport-side master for the DMI bus: the requesting end of the DM's register interface.
- Accepts one DMI operation (read, write or nop) from the transport front end, which is already synchronised into iClk. Drives a single access onto the DM register port and waits for the DM's acknowledge.
- Returns a response pulse carrying the read data and a DMI status code (0 success, 2 failed, 3 busy).
- Keeps the sticky dmistat that the debugger clears with dmireset.

Parameters:
- ABITS, 7, DMI address width.
- TIMEOUT, 64, cycles to wait in ACCESS for iDmAck before reporting failure (legal range >= 2).

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset: synchronous, active-high, sampled on rising edge of iClk.
- iReqValid  in  1  request strobe, qualified by oReqReady.
- iReqOp  in  2  0 = nop, 1 = read, 2 = write, 3 = reserved (treated as nop).
- iReqAddr  in  ABITS  DM register address.
- iReqData  in  32  write data.
- iDmiReset  in  1  clears sticky dmistat.
- iDmiHardReset  in  1  aborts any access and returns to idle.
- oReqReady  out  1  high only in IDLE.
- oRespValid  out  1  one-cycle response pulse.
- oRespOp  out  2  response status.
- oRespData  out  32  read data (0 for writes and nops).
- oDmiStat  out  2  current sticky status.
- oDmAddr  out  ABITS  access address to DM.
- oDmWdata  out  32  access write data.
- oDmWrite  out  1  1 = write, 0 = read.
- oDmAccessValid  out  1  access request, held until ack.
- iDmRdata  in  32  DM read data, valid with iDmAck.
- iDmAck  in  1  DM completes access this cycle.
- iDmError  in  1  DM flags access error, valid with iDmAck.

Behaviour:
- Reset (iRst = 1):
  - State goes to IDLE; stat = 0; timeout counter = 0.
  - All outputs are 0 except oReqReady = 1.
  - iRst overrides every other input.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - oReqReady = 1.
  - On iReqValid at cycle N, latch op/addr/data.
  - If stat != 0, or op is nop/reserved: go to RESP (N+1), no DM access. oRespOp = stat, oRespData = 0.
  - Else: go to ACCESS (N+1). oDmAccessValid = 1 from N+1, oDmAddr/oDmWdata/oDmWrite driven from the latched values.
- ACCESS:
  - oDmAccessValid and payload are held stable until iDmAck is sampled high.
  - Counter increments each ACCESS cycle, starting at 1 on the first ACCESS cycle.
  - iDmAck at cycle M: capture iDmRdata (reads only) and go to RESP at M+1.
    - oRespOp = 2 if iDmError, else 0.
    - On error: stat <- 2 if stat == 0.
  - No ack when counter == TIMEOUT:
    - Drop oDmAccessValid and go to RESP next cycle.
    - oRespOp = 2, oRespData = 0; stat <- 2 if stat == 0.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - oRespValid = 1 for exactly one cycle with oRespOp/oRespData.
  - Next state IDLE; counter cleared.
  - Minimum latency, accept to response: 2 cycles (ack on first ACCESS cycle).
- Busy violation:
  - iReqValid while oReqReady = 0 (ACCESS or RESP): request dropped, stat <- 3 if stat == 0.
  - In-flight access is unaffected.
- Sticky rule:
  - stat changes from 0 only, and is first-error-wins.
  - iDmiReset forces stat to 0 and wins over a same-cycle set.
  - iDmiReset does not abort an in-flight access.
- iDmiHardReset, any state:
  - Next cycle: IDLE, stat = 0, counter = 0, oDmAccessValid = 0.
  - No response pulse for the aborted access; a same-cycle iReqValid is ignored.
- oRespData and oRespOp are 0 whenever oRespValid = 0.
- oDmAddr, oDmWdata and oDmWrite are 0 outside ACCESS.

Test Plan:
- Write: op = 2, addr = 0x04, data = 0xDEADBEEF; DM acks on the 3rd ACCESS cycle -> oDmAccessValid high 3 cycles with oDmWrite = 1; response op 0, data 0; stat stays 0.
- Read: op = 1, addr = 0x11; DM acks in the first ACCESS cycle with iDmRdata = 0x00400C82 -> oRespValid exactly 2 cycles after accept, oRespData = 0x00400C82, op 0.
- Busy: iReqValid pulsed during ACCESS -> request dropped, stat = 3. Next read returns op 3 with no DM access. iDmiReset -> stat 0, and the following read succeeds.
- Timeout: TIMEOUT = 64, DM never acks -> oDmAccessValid high exactly 64 cycles, response op 2, stat = 2. A subsequent iDmError does not change stat.
- Error/priority: iDmAck + iDmError -> op 2. Ack coinciding with the final timeout cycle -> ack data returned. iDmiReset with a same-cycle busy violation -> stat 0.
- Abort: iDmiHardReset mid-ACCESS -> next cycle IDLE, oDmAccessValid 0, no oRespValid. iRst mid-RESP -> oRespValid 0 next cycle and all outputs return to reset values.
